fractcam_lookup: RTL and testbench

FRACTCAM_LOOKUP -- requirements
Module: fractcam_lookup

---
 rtl/fractcam_pkg.sv | 26 ++
 rtl/fractcam_prio_enc.sv | 20 ++
 rtl/fractcam_lookup.sv | 179 +++++++++++++++++
 tb/tb_fractcam_lookup.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractcam_pkg.sv
// Shared definitions for the FracTCAM lookup block.
// Update FSM encoding, LUT chunk legality limits and size helpers.
package fractcam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } upd_state_t;

    localparam int LUT_BITS_MIN = 5;
    localparam int LUT_BITS_MAX = 6;

    function automatic bit lut_bits_ok(int lb);
        return (lb >= LUT_BITS_MIN) && (lb <= LUT_BITS_MAX);
    endfunction

    function automatic int calc_chunks(int dw, int lb);
        return (dw + lb - 1) / lb;
    endfunction

    function automatic int calc_aw(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fractcam_prio_enc.sv
// Lowest-index-wins priority encoder, purely combinational.
// The parent registers idx/hit.
module fractcam_prio_enc #(
    parameter int W = 16,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          hit
);

    always_comb begin
        idx = '0;
        hit = |req;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/fractcam_lookup.sv
// LUT-based (FracTCAM) ternary lookup: serial rule load, 2-stage search.
// Each entry holds one 2^LUT_BITS truth table per key chunk.
module fractcam_lookup
    import fractcam_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TCAM_DEPTH = 16,
    parameter int LUT_BITS   = 5,
    localparam int AW = calc_aw(TCAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_keep,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         del_addr,
    input  logic                  del_valid,
    output logic                  del_ready,
    input  logic [DATA_WIDTH-1:0] search_key,
    input  logic                  search_valid,
    output logic                  search_ready,
    output logic [TCAM_DEPTH-1:0] match_line,
    output logic [AW-1:0]         match_index,
    output logic                  match_hit,
    output logic                  match_valid,
    input  logic                  match_ready,
    output logic [AW:0]           entry_count,
    output logic                  busy
);

    localparam int CHUNKS = calc_chunks(DATA_WIDTH, LUT_BITS);
    localparam int PW     = CHUNKS * LUT_BITS;
    localparam int NV     = 1 << LUT_BITS;

    upd_state_t            state;
    logic [LUT_BITS-1:0]   cnt;
    logic [AW-1:0]         wa_q;
    logic [PW-1:0]         wd_q;
    logic [PW-1:0]         wk_q;
    logic [TCAM_DEPTH-1:0] valid;

    logic [TCAM_DEPTH-1:0][CHUNKS-1:0][NV-1:0] lut;

    logic [CHUNKS-1:0]     shift_bit;
    logic [PW-1:0]         key_pad;
    logic [TCAM_DEPTH-1:0] hit_vec;

    logic                  s1_valid;
    logic [TCAM_DEPTH-1:0] s1_line;
    logic [AW-1:0]         pe_idx;
    logic                  pe_hit;

    logic wr_fire;
    logic del_fire;
    logic srch_fire;
    logic s2_adv;

    assign busy      = (state != ST_IDLE);
    assign del_ready = (state == ST_IDLE);
    // Delete wins a tie with write; write waits for an empty stage 1.
    assign wr_ready  = (state == ST_IDLE) && !s1_valid && !del_valid;
    assign s2_adv    = !match_valid || match_ready;
    assign search_ready = (state == ST_IDLE) &&
                          !(s1_valid && match_valid && !match_ready);

    assign wr_fire   = wr_valid && wr_ready;
    assign del_fire  = del_valid && del_ready;
    assign srch_fire = search_valid && search_ready;

    assign key_pad   = PW'(search_key);

    // Truth-table bit for chunk value == cnt; padded bits have keep 0.
    always_comb begin
        shift_bit = '1;
        for (int c = 0; c < CHUNKS; c++) begin
            for (int j = 0; j < LUT_BITS; j++) begin
                if (wk_q[c*LUT_BITS+j] && (wd_q[c*LUT_BITS+j] != cnt[j]))
                    shift_bit[c] = 1'b0;
            end
        end
    end

    always_comb begin
        hit_vec = '0;
        for (int e = 0; e < TCAM_DEPTH; e++) begin
            hit_vec[e] = valid[e];
            for (int c = 0; c < CHUNKS; c++) begin
                hit_vec[e] = hit_vec[e] &
                    lut[e][c][key_pad[c*LUT_BITS +: LUT_BITS]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_SHIFT) begin
            for (int c = 0; c < CHUNKS; c++) begin
                lut[wa_q][c] <= {shift_bit[c], lut[wa_q][c][NV-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wa_q        <= '0;
            wd_q        <= '0;
            wk_q        <= '0;
            valid       <= '0;
            entry_count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (del_fire) begin
                        valid[del_addr] <= 1'b0;
                        if (valid[del_addr])
                            entry_count <= entry_count - (AW+1)'(1);
                    end else if (wr_fire) begin
                        wa_q           <= wr_addr;
                        wd_q           <= PW'(wr_data);
                        wk_q           <= PW'(wr_keep);
                        valid[wr_addr] <= 1'b0;
                        if (valid[wr_addr])
                            entry_count <= entry_count - (AW+1)'(1);
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt + LUT_BITS'(1);
                    if (&cnt) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    valid[wa_q] <= 1'b1;
                    entry_count <= entry_count + (AW+1)'(1);
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fractcam_prio_enc #(
        .W(TCAM_DEPTH)
    ) u_prio (
        .req (s1_line),
        .idx (pe_idx),
        .hit (pe_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_line     <= '0;
            match_valid <= 1'b0;
            match_line  <= '0;
            match_index <= '0;
            match_hit   <= 1'b0;
        end else begin
            if (srch_fire) begin
                s1_valid <= 1'b1;
                s1_line  <= hit_vec;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) begin
                match_valid <= s1_valid;
                if (s1_valid) begin
                    match_line  <= s1_line;
                    match_index <= pe_idx;
                    match_hit   <= pe_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_fractcam_lookup.sv
// Directed + randomized bench for fractcam_lookup.
// Reference: per-entry (data, keep, valid) table evaluated arithmetically.
module tb_fractcam_lookup;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LB    = 5;
    localparam int AW    = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   wr_keep;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   del_addr;
    logic            del_valid;
    logic            del_ready;
    logic [DW-1:0]   search_key;
    logic            search_valid;
    logic            search_ready;
    logic [DEPTH-1:0] match_line;
    logic [AW-1:0]   match_index;
    logic            match_hit;
    logic            match_valid;
    logic            match_ready;
    logic [AW:0]     entry_count;
    logic            busy;

    always #5 clk = ~clk;

    fractcam_lookup #(
        .DATA_WIDTH (DW),
        .TCAM_DEPTH (DEPTH),
        .LUT_BITS   (LB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_keep      (wr_keep),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .del_addr     (del_addr),
        .del_valid    (del_valid),
        .del_ready    (del_ready),
        .search_key   (search_key),
        .search_valid (search_valid),
        .search_ready (search_ready),
        .match_line   (match_line),
        .match_index  (match_index),
        .match_hit    (match_hit),
        .match_valid  (match_valid),
        .match_ready  (match_ready),
        .entry_count  (entry_count),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_data [DEPTH];
    logic [DW-1:0] m_keep [DEPTH];
    bit            m_valid[DEPTH];

    function automatic logic [DEPTH-1:0] ref_line(logic [DW-1:0] key);
        logic [DEPTH-1:0] r;
        r = '0;
        for (int e = 0; e < DEPTH; e++)
            r[e] = m_valid[e] && (((key ^ m_data[e]) & m_keep[e]) == '0);
        return r;
    endfunction

    function automatic int ref_count();
        int n;
        n = 0;
        for (int e = 0; e < DEPTH; e++) n += int'(m_valid[e]);
        return n;
    endfunction

    function automatic int lowest(logic [DEPTH-1:0] line);
        int r;
        r = 0;
        for (int i = DEPTH - 1; i >= 0; i--) if (line[i]) r = i;
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int e = 0; e < DEPTH; e++) begin
            m_valid[e] = 0;
            m_data[e]  = '0;
            m_keep[e]  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        wr_valid     = 1'b0;
        del_valid    = 1'b0;
        search_valid = 1'b0;
        match_ready  = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic write_entry(int addr, logic [DW-1:0] d, logic [DW-1:0] k);
        int n;
        wr_addr  = AW'(addr);
        wr_data  = d;
        wr_keep  = k;
        wr_valid = 1'b1;
        #1;
        n = 0;
        while (!wr_ready && n < 200) begin
            tick();
            n++;
        end
        if (!wr_ready) check("wr_ready_wait", 64'(wr_ready), 1);
        tick();
        wr_valid      = 1'b0;
        m_valid[addr] = 0;
        m_data[addr]  = d;
        m_keep[addr]  = k;
        check("wr_busy", 64'(busy), 1);
        check("wr_count_mid", 64'(entry_count), 64'(ref_count()));
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("wr_done", 64'(busy), 0);
        m_valid[addr] = 1;
    endtask

    task automatic delete_entry(int addr);
        int n;
        del_addr  = AW'(addr);
        del_valid = 1'b1;
        #1;
        n = 0;
        while (!del_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        del_valid     = 1'b0;
        m_valid[addr] = 0;
        check("del_count", 64'(entry_count), 64'(ref_count()));
    endtask

    task automatic search_check(string tag, logic [DW-1:0] key);
        logic [DEPTH-1:0] exp;
        int n;
        match_ready  = 1'b1;
        search_key   = key;
        search_valid = 1'b1;
        #1;
        n = 0;
        while (!search_ready && n < 200) begin
            tick();
            n++;
        end
        exp = ref_line(key);
        tick();
        search_valid = 1'b0;
        check({tag, "_lat1"}, 64'(match_valid), 0);
        tick();
        check({tag, "_valid"}, 64'(match_valid), 1);
        check({tag, "_line"}, 64'(match_line), 64'(exp));
        check({tag, "_hit"}, 64'(match_hit), 64'(|exp));
        check({tag, "_idx"}, 64'(match_index), 64'(lowest(exp)));
    endtask

    logic [DEPTH-1:0] q_line[$];
    logic [DEPTH-1:0] exp_l;
    logic [DEPTH-1:0] p_line;
    logic [AW-1:0]    p_idx;
    logic             p_hit;
    bit               p_stall;
    bit               saw_block;
    int               k;
    int               hi_cnt;
    int               nsent;
    int               ngot;

    initial begin
        rst_n        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        wr_keep      = '0;
        wr_valid     = 1'b0;
        del_addr     = '0;
        del_valid    = 1'b0;
        search_key   = '0;
        search_valid = 1'b0;
        match_ready  = 1'b1;
        model_clear();

        repeat (2) tick();
        check("rst_wr_ready", 64'(wr_ready), 1);
        check("rst_del_ready", 64'(del_ready), 1);
        check("rst_search_ready", 64'(search_ready), 1);
        check("rst_busy", 64'(busy), 0);
        check("rst_match_valid", 64'(match_valid), 0);
        check("rst_match_hit", 64'(match_hit), 0);
        check("rst_match_index", 64'(match_index), 0);
        check("rst_match_line", 64'(match_line), 0);
        check("rst_count", 64'(entry_count), 0);
        rst_n = 1'b1;
        tick();

        write_entry(3, 8'hA5, 8'hFF);
        check("e3_count", 64'(entry_count), 1);
        search_check("s_a5", 8'hA5);
        check("s_a5_line_lit", 64'(match_line), 64'h0008);
        check("s_a5_idx_lit", 64'(match_index), 3);
        check("s_a5_hit_lit", 64'(match_hit), 1);
        search_check("s_a4", 8'hA4);
        check("s_a4_hit_lit", 64'(match_hit), 0);
        check("s_a4_idx_lit", 64'(match_index), 0);

        do_reset();
        wr_addr  = 4'd5;
        wr_data  = 8'h30;
        wr_keep  = 8'hF0;
        wr_valid = 1'b1;
        #1;
        check("t_ready_pre", 64'(wr_ready), 1);
        tick();
        wr_valid   = 1'b0;
        m_data[5]  = 8'h30;
        m_keep[5]  = 8'hF0;
        k      = 1;
        hi_cnt = 0;
        while (!wr_ready && k < 100) begin
            if (search_ready) hi_cnt++;
            tick();
            k++;
        end
        m_valid[5] = 1;
        check("t_wr_turnaround", 64'(k), 34);
        check("t_srch_ready_low", 64'(hi_cnt), 0);

        write_entry(9, 8'h3F, 8'hFF);
        search_check("s_3f", 8'h3F);
        check("s_3f_line_lit", 64'(match_line), 64'h0220);
        check("s_3f_idx_lit", 64'(match_index), 5);
        check("s_3f_count_lit", 64'(entry_count), 2);

        del_addr  = 4'd5;
        del_valid = 1'b1;
        wr_addr   = 4'd7;
        wr_data   = 8'h77;
        wr_keep   = 8'hFF;
        wr_valid  = 1'b1;
        #1;
        check("tie_del_ready", 64'(del_ready), 1);
        check("tie_wr_ready", 64'(wr_ready), 0);
        tick();
        del_valid  = 1'b0;
        m_valid[5] = 0;
        #1;
        check("tie_count_del", 64'(entry_count), 1);
        check("tie_wr_next", 64'(wr_ready), 1);
        tick();
        wr_valid  = 1'b0;
        m_data[7] = 8'h77;
        m_keep[7] = 8'hFF;
        check("tie_wr_busy", 64'(busy), 1);
        k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        m_valid[7] = 1;
        search_check("s_tie", 8'h3F);
        check("s_tie_idx_lit", 64'(match_index), 9);
        check("s_tie_count_lit", 64'(entry_count), 2);

        write_entry(9, 8'h3F, 8'hFF);
        check("rewrite_count", 64'(entry_count), 2);
        delete_entry(12);
        check("del_invalid_count", 64'(entry_count), 2);

        for (int i = 0; i < 6; i++) begin
            write_entry($urandom_range(0, DEPTH - 1), DW'($urandom),
                        $urandom_range(0, 1) ? 8'hFF : DW'($urandom));
        end
        check("rand_count", 64'(entry_count), 64'(ref_count()));

        p_stall   = 0;
        saw_block = 0;
        nsent     = 0;
        ngot      = 0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(posedge clk);
            #1;
            if (p_stall) begin
                check("hold_valid", 64'(match_valid), 1);
                check("hold_line", 64'(match_line), 64'(p_line));
                check("hold_idx", 64'(match_index), 64'(p_idx));
                check("hold_hit", 64'(match_hit), 64'(p_hit));
            end
            search_valid = (cyc < 60) &&
                           ((cyc >= 3 && cyc < 10) || $urandom_range(0, 3) != 0);
            search_key = $urandom_range(0, 1) ?
                         m_data[$urandom_range(0, DEPTH - 1)] : DW'($urandom);
            if (cyc >= 5 && cyc < 9)
                match_ready = 1'b0;
            else
                match_ready = (cyc >= 60) || ($urandom_range(0, 4) != 0);
            del_valid = (cyc < 60) && ($urandom_range(0, 11) == 0);
            del_addr  = AW'($urandom_range(0, DEPTH - 1));
            #1;
            if (cyc >= 5 && cyc < 9 && !search_ready) saw_block = 1;
            if (match_valid && match_ready) begin
                check("sb_nonempty", 64'(q_line.size() > 0), 1);
                if (q_line.size() > 0) begin
                    exp_l = q_line.pop_front();
                    ngot++;
                    check("sb_line", 64'(match_line), 64'(exp_l));
                    check("sb_hit", 64'(match_hit), 64'(|exp_l));
                    check("sb_idx", 64'(match_index), 64'(lowest(exp_l)));
                end
            end
            if (search_valid && search_ready) begin
                q_line.push_back(ref_line(search_key));
                nsent++;
            end
            if (del_valid && del_ready) m_valid[del_addr] = 0;
            p_stall = match_valid && !match_ready;
            p_line  = match_line;
            p_idx   = match_index;
            p_hit   = match_hit;
        end
        search_valid = 1'b0;
        del_valid    = 1'b0;
        match_ready  = 1'b1;
        tick();
        check("sb_drained", 64'(q_line.size()), 0);
        check("sb_all_recv", 64'(ngot), 64'(nsent));
        check("sb_stall_seen", 64'(saw_block), 1);
        check("sb_count", 64'(entry_count), 64'(ref_count()));

        wr_addr  = 4'd2;
        wr_data  = 8'h5C;
        wr_keep  = 8'hFF;
        wr_valid = 1'b1;
        #1;
        k = 0;
        while (!wr_ready && k < 200) begin
            tick();
            k++;
        end
        tick();
        wr_valid = 1'b0;
        repeat (10) tick();
        check("mid_busy", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mr_wr_ready", 64'(wr_ready), 1);
        check("mr_del_ready", 64'(del_ready), 1);
        check("mr_search_ready", 64'(search_ready), 1);
        check("mr_busy", 64'(busy), 0);
        check("mr_match_valid", 64'(match_valid), 0);
        check("mr_match_hit", 64'(match_hit), 0);
        check("mr_match_index", 64'(match_index), 0);
        check("mr_match_line", 64'(match_line), 0);
        check("mr_count", 64'(entry_count), 0);
        tick();
        rst_n = 1'b1;
        tick();
        model_clear();
        search_check("s_after_rst", 8'h5C);
        check("s_after_rst_hit_lit", 64'(match_hit), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
